// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of the sdram controller.
// Read responses are routed back in order through a tag FIFO of port IDs.
module sdram_arbiter #(
    parameter int AW        = 24,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c0_valid,
    input  logic          c0_we,
    input  logic [AW-1:0] c0_addr,
    input  logic [DW-1:0] c0_data,
    output logic          c0_ready,
    output logic [DW-1:0] c0_rdata,
    output logic          c0_rvalid,
    input  logic          c1_valid,
    input  logic          c1_we,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c1_data,
    output logic          c1_ready,
    output logic [DW-1:0] c1_rdata,
    output logic          c1_rvalid,
    output logic          avalid,
    output logic          awe,
    output logic [AW-1:0] aaddr,
    output logic [DW-1:0] adata,
    input  logic          aready,
    input  logic [DW-1:0] bdata,
    input  logic          bvalid,
    output logic          err
);

    localparam int TW = $clog2(TAG_DEPTH);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [1:0] {
        IDLE,
        G0,
        G1
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          rr;
    logic          rr_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    logic [TAG_DEPTH-1:0] tag_mem;
    logic [TW:0]          wp;
    logic [TW:0]          rp;
    logic                 tag_full;
    logic                 tag_empty;
    logic                 push;
    logic                 pop;
    logic                 head;

    assign tag_empty = (wp == rp);
    assign tag_full  = (wp[TW] != rp[TW]) &&
                       (wp[TW-1:0] == rp[TW-1:0]);
    assign head      = tag_mem[rp[TW-1:0]];
    assign pop       = bvalid && !tag_empty;
    assign push      = (c0_ready || c1_ready) && !awe;

    always_comb begin
        state_nx = state;
        rr_nx    = rr;
        cnt_nx   = cnt;
        avalid   = 1'b0;
        awe      = c0_we;
        aaddr    = c0_addr;
        adata    = c0_data;
        c0_ready = 1'b0;
        c1_ready = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (c0_valid && c1_valid)
                    state_nx = rr ? G1 : G0;
                else if (c0_valid)
                    state_nx = G0;
                else if (c1_valid)
                    state_nx = G1;
            end
            G0: begin
                avalid   = c0_valid && (c0_we || !tag_full);
                c0_ready = avalid && aready;
                if (c0_ready) begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt == CW'(MAX_BURST - 1)) begin
                        state_nx = IDLE;
                        rr_nx    = 1'b1;
                    end
                end else if (!c0_valid) begin
                    state_nx = IDLE;
                    rr_nx    = 1'b1;
                end
            end
            G1: begin
                awe      = c1_we;
                aaddr    = c1_addr;
                adata    = c1_data;
                avalid   = c1_valid && (c1_we || !tag_full);
                c1_ready = avalid && aready;
                if (c1_ready) begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt == CW'(MAX_BURST - 1)) begin
                        state_nx = IDLE;
                        rr_nx    = 1'b0;
                    end
                end else if (!c1_valid) begin
                    state_nx = IDLE;
                    rr_nx    = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= 1'b0;
            cnt       <= '0;
            wp        <= '0;
            rp        <= '0;
            c0_rvalid <= 1'b0;
            c1_rvalid <= 1'b0;
            c0_rdata  <= '0;
            c1_rdata  <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nx;
            rr    <= rr_nx;
            cnt   <= cnt_nx;
            if (push) begin
                tag_mem[wp[TW-1:0]] <= (state == G1);
                wp <= wp + (TW+1)'(1);
            end
            if (pop)
                rp <= rp + (TW+1)'(1);
            // head is the issuing port of the oldest read
            c0_rvalid <= pop && !head;
            c1_rvalid <= pop && head;
            if (pop && !head)
                c0_rdata <= bdata;
            if (pop && head)
                c1_rdata <= bdata;
            if (bvalid && tag_empty)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: queue-based arbitration model plus a small
// in-order sdram responder, with directed scenarios and random traffic.
module tb_sdram_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int MB = 8;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c0_valid = 1'b0;
    logic          c0_we = 1'b0;
    logic [AW-1:0] c0_addr = '0;
    logic [DW-1:0] c0_data = '0;
    logic          c1_valid = 1'b0;
    logic          c1_we = 1'b0;
    logic [AW-1:0] c1_addr = '0;
    logic [DW-1:0] c1_data = '0;
    logic          aready = 1'b0;
    logic          bvalid = 1'b0;
    logic [DW-1:0] bdata = '0;
    logic          c0_ready, c1_ready;
    logic          c0_rvalid, c1_rvalid;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic          avalid, awe, err;
    logic [AW-1:0] aaddr;
    logic [DW-1:0] adata;

    sdram_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(MB), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_valid(c0_valid), .c0_we(c0_we),
        .c0_addr(c0_addr), .c0_data(c0_data),
        .c0_ready(c0_ready), .c0_rdata(c0_rdata),
        .c0_rvalid(c0_rvalid),
        .c1_valid(c1_valid), .c1_we(c1_we),
        .c1_addr(c1_addr), .c1_data(c1_data),
        .c1_ready(c1_ready), .c1_rdata(c1_rdata),
        .c1_rvalid(c1_rvalid),
        .avalid(avalid), .awe(awe), .aaddr(aaddr),
        .adata(adata), .aready(aready),
        .bdata(bdata), .bvalid(bvalid), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    req_t          q0[$];
    req_t          q1[$];
    rsp_t          pend[$];
    logic [DW-1:0] mem[int];
    int            cyc = 0;
    bit            acc0, acc1;
    int            ar_mode = 1;
    bit            hold_b = 0;
    int            inj = 0;
    int            lat_max = 1;
    int            gl[$];
    int            ga[$];
    int            gc[$];
    int            rl_p[$];
    int            rl_d[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            mon_en = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: owner of the grant, transfers in the current
    // burst, preferred port, and a queue of issuing ports for reads.
    int            own = -1;
    int            pref = 0;
    int            bc = 0;
    int            tags[$];
    logic          mrv[2] = '{1'b0, 1'b0};
    logic [DW-1:0] mrd[2] = '{'0, '0};
    logic          merr = 1'b0;

    always @(negedge clk) begin
        bit ea, r0, r1, full, ownv;
        int p;
        if (mon_en) begin
            full = (tags.size() == TD);
            ea = 0;
            if (own == 0) ea = c0_valid && (c0_we || !full);
            if (own == 1) ea = c1_valid && (c1_we || !full);
            r0 = ea && (own == 0) && aready;
            r1 = ea && (own == 1) && aready;
            chk("avalid", avalid, ea);
            chk("c0_ready", c0_ready, r0);
            chk("c1_ready", c1_ready, r1);
            if (ea) begin
                chk("awe", awe, own == 0 ? c0_we : c1_we);
                chk("aaddr", aaddr, own == 0 ? c0_addr : c1_addr);
                chk("adata", adata, own == 0 ? c0_data : c1_data);
            end
            chk("c0_rvalid", c0_rvalid, mrv[0]);
            chk("c1_rvalid", c1_rvalid, mrv[1]);
            chk("c0_rdata", c0_rdata, mrd[0]);
            chk("c1_rdata", c1_rdata, mrd[1]);
            chk("err", err, merr);
            if (!rst_n) begin
                own = -1; pref = 0; bc = 0;
                tags.delete();
                mrv[0] = 0; mrv[1] = 0;
                mrd[0] = '0; mrd[1] = '0;
                merr = 0;
            end else begin
                mrv[0] = 0; mrv[1] = 0;
                if (bvalid) begin
                    if (tags.size() > 0) begin
                        p = tags.pop_front();
                        mrv[p] = 1;
                        mrd[p] = bdata;
                    end else begin
                        merr = 1;
                    end
                end
                if ((r0 && !c0_we) || (r1 && !c1_we))
                    tags.push_back(own);
                ownv = (own == 0) ? c0_valid : c1_valid;
                if (own < 0) begin
                    bc = 0;
                    if (c0_valid && c1_valid) own = pref;
                    else if (c0_valid) own = 0;
                    else if (c1_valid) own = 1;
                end else if (r0 || r1) begin
                    bc++;
                    if (bc == MB) begin
                        pref = 1 - own;
                        own = -1;
                    end
                end else if (!ownv) begin
                    pref = 1 - own;
                    own = -1;
                end
            end
        end
    end

    // One clock: sample handshakes at negedge, drive after posedge.
    task automatic step();
        @(negedge clk);
        acc0 = c0_ready;
        acc1 = c1_ready;
        if (rst_n && avalid && aready) begin
            gl.push_back(c1_ready ? 1 : 0);
            ga.push_back(int'(aaddr));
            gc.push_back(cyc);
            if (awe) begin
                mem[int'(aaddr)] = adata;
            end else begin
                rsp_t r;
                r.data = mem.exists(int'(aaddr)) ?
                         mem[int'(aaddr)] : '0;
                r.due = cyc + 1 + int'($urandom % lat_max);
                pend.push_back(r);
            end
        end
        if (c0_rvalid) begin
            rl_p.push_back(0); rl_d.push_back(int'(c0_rdata));
        end
        if (c1_rvalid) begin
            rl_p.push_back(1); rl_d.push_back(int'(c1_rdata));
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) pend.delete();
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        c0_valid = (q0.size() > 0);
        if (c0_valid) begin
            c0_we = q0[0].we; c0_addr = q0[0].addr; c0_data = q0[0].data;
        end
        c1_valid = (q1.size() > 0);
        if (c1_valid) begin
            c1_we = q1[0].we; c1_addr = q1[0].addr; c1_data = q1[0].data;
        end
        case (ar_mode)
            0: aready = (($urandom % 10) < 7);
            1: aready = 1'b1;
            default: aready = 1'b0;
        endcase
        if (inj > 0) begin
            bvalid = 1'b1; bdata = 16'hbad0; inj = 0;
        end else if (!hold_b && pend.size() > 0 && pend[0].due <= cyc) begin
            bvalid = 1'b1; bdata = pend[0].data;
            void'(pend.pop_front());
        end else begin
            bvalid = 1'b0;
        end
        #1;
    endtask

    task automatic drain(int maxc);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || c0_valid || c1_valid ||
                pend.size() > 0 || bvalid) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < maxc, 1);
        repeat (2) step();
    endtask

    task automatic clear_logs();
        gl.delete(); ga.delete(); gc.delete();
        rl_p.delete(); rl_d.delete();
    endtask

    initial begin
        int n, k0, k1, ep, ea;
        // reset
        rst_n = 1'b0;
        repeat (2) step();
        mon_en = 1;
        step();
        chk("rst_err", err, 0);
        chk("rst_avalid", avalid, 0);
        chk("rst_c0_rvalid", c0_rvalid, 0);
        chk("rst_c1_rvalid", c1_rvalid, 0);
        chk("rst_c0_rdata", c0_rdata, 0);
        chk("rst_c1_rdata", c1_rdata, 0);
        rst_n = 1'b1;

        // single port writes
        ar_mode = 0;
        clear_logs();
        for (int i = 0; i < 5; i++)
            q0.push_back('{1'b1, AW'(i + 1), DW'(i)});
        drain(200);
        chk("single_xfers", gl.size(), 5);
        n = 0;
        foreach (gl[i]) n += gl[i];
        chk("single_port1_xfers", n, 0);
        chk("single_no_rvalid", rl_p.size(), 0);
        chk("single_mem5", mem[5], 4);

        // contention from reset
        ar_mode = 1;
        rst_n = 1'b0;
        clear_logs();
        for (int i = 0; i < 20; i++) begin
            q0.push_back('{1'b1, AW'(24'h100 + i), DW'(i)});
            q1.push_back('{1'b1, AW'(24'h200 + i), DW'(i)});
        end
        repeat (2) step();
        rst_n = 1'b1;
        drain(400);
        chk("cont_xfers", gl.size(), 40);
        k0 = 0; k1 = 0;
        for (int i = 0; i < gl.size() && i < 40; i++) begin
            ep = (i < 32) ? ((i / 8) % 2) : ((i < 36) ? 0 : 1);
            ea = ep ? (24'h200 + k1) : (24'h100 + k0);
            if (ep) k1++; else k0++;
            chk("cont_port", gl[i], ep);
            chk("cont_aaddr", ga[i], ea);
        end
        if (gc.size() >= 9) begin
            chk("cont_burst_back2back", gc[7] - gc[0], 7);
            chk("cont_handover_gap", gc[8] - gc[7], 2);
        end else begin
            chk("cont_log_len", gc.size(), 40);
        end

        // read routing
        clear_logs();
        q0.push_back('{1'b1, AW'(2), DW'(1)});
        q1.push_back('{1'b1, AW'(3), DW'(42)});
        drain(100);
        q0.push_back('{1'b0, AW'(2), DW'(0)});
        drain(100);
        q1.push_back('{1'b0, AW'(3), DW'(0)});
        drain(100);
        q0.push_back('{1'b0, AW'(2), DW'(0)});
        drain(100);
        chk("route_count", rl_p.size(), 3);
        if (rl_p.size() == 3) begin
            chk("route_p0", rl_p[0], 0); chk("route_d0", rl_d[0], 1);
            chk("route_p1", rl_p[1], 1); chk("route_d1", rl_d[1], 42);
            chk("route_p2", rl_p[2], 0); chk("route_d2", rl_d[2], 1);
        end

        // tag FIFO full
        clear_logs();
        hold_b = 1;
        for (int i = 0; i < 5; i++)
            q1.push_back('{1'b0, AW'(3), DW'(0)});
        repeat (12) step();
        chk("tf_accepted", gl.size(), 4);
        chk("tf_c1_valid", c1_valid, 1);
        chk("tf_stalled", avalid, 0);
        hold_b = 0;
        step();
        chk("tf_first_bvalid", bvalid, 1);
        chk("tf_still_stalled", avalid, 0);
        step();
        chk("tf_accept_after_pop", c1_ready, 1);
        drain(100);
        chk("tf_responses", rl_p.size(), 5);

        // error, then reset mid-burst with reads outstanding
        inj = 1;
        repeat (2) step();
        chk("err_set", err, 1);
        clear_logs();
        hold_b = 1;
        q0.push_back('{1'b0, AW'(2), DW'(0)});
        q0.push_back('{1'b0, AW'(2), DW'(0)});
        for (int i = 0; i < 10; i++)
            q0.push_back('{1'b1, AW'(24'h300 + i), DW'(i)});
        n = 0;
        while (gl.size() < 4 && n < 50) begin
            step();
            n++;
        end
        chk("er_burst_started", n < 50, 1);
        rst_n = 1'b0;
        aready = 1'b0;
        ar_mode = 2;
        step();
        rst_n = 1'b1;
        chk("er_err_clr", err, 0);
        chk("er_avalid", avalid, 0);
        chk("er_c0_rvalid", c0_rvalid, 0);
        chk("er_c1_rvalid", c1_rvalid, 0);
        ar_mode = 1;
        hold_b = 0;
        clear_logs();
        drain(200);
        chk("er_no_responses", rl_p.size(), 0);
        inj = 1;
        repeat (2) step();
        chk("er_fifo_empty", err, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // random traffic
        ar_mode = 0;
        lat_max = 4;
        for (int c = 0; c < 3000; c++) begin
            if (q0.size() < 3 && ($urandom % 3) == 0)
                q0.push_back('{1'($urandom), AW'($urandom % 16),
                               DW'($urandom)});
            if (q1.size() < 3 && ($urandom % 3) == 0)
                q1.push_back('{1'($urandom), AW'($urandom % 16),
                               DW'($urandom)});
            step();
        end
        drain(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
